// File: rtl/fd_linebuf_sched.sv
// Triple-bank line buffer scheduler: an input writer fills free banks, a reader
// replays each completed line twice (line doubling) in arrival order.
module fd_linebuf_sched #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              masterclk,
    input  logic              rst,
    input  logic              in_line_start,
    input  logic              in_pix_en,
    input  logic              in_line_end,
    input  logic              out_line_start,
    input  logic              out_pix_en,
    output logic              wr_en,
    output logic [ADDR_W+1:0] wr_addr,
    output logic [ADDR_W+1:0] rd_addr,
    output logic              rd_valid,
    output logic              overrun,
    output logic              underrun
);
    localparam int unsigned NB = 3;
    localparam int unsigned BW = 2;
    localparam int unsigned LW = ADDR_W + 1;
    localparam logic [LW-1:0] LINE_MAX = LW'(2 ** ADDR_W);

    typedef enum logic [1:0] {B_FREE, B_WRITING, B_READY, B_READING} bank_st_e;
    typedef enum logic {W_IDLE, W_FILL} wr_st_e;
    typedef enum logic [1:0] {R_IDLE, R_PASS0, R_PASS1} rd_st_e;

    bank_st_e        r_bank_st [NB];
    logic [LW-1:0]   r_len     [NB];
    logic [BW-1:0]   r_fifo    [NB];
    logic [1:0]      r_fifo_cnt;
    wr_st_e          r_wr_state;
    logic [BW-1:0]   r_wr_bank;
    logic [LW-1:0]   r_wr_ptr;
    rd_st_e          r_rd_state;
    logic [BW-1:0]   r_rd_bank;
    logic [LW-1:0]   r_rd_ptr;
    logic            r_overrun;
    logic            r_underrun;

    bank_st_e        w_bank_st [NB];
    logic [LW-1:0]   w_len     [NB];
    logic [BW-1:0]   w_fifo    [NB];
    logic [1:0]      w_fifo_cnt;
    wr_st_e          w_wr_state;
    logic [BW-1:0]   w_wr_bank;
    logic [LW-1:0]   w_wr_ptr;
    rd_st_e          w_rd_state;
    logic [BW-1:0]   w_rd_bank;
    logic [LW-1:0]   w_rd_ptr;
    logic            w_overrun;
    logic            w_underrun;
    logic            w_free_found;
    logic [BW-1:0]   w_free_idx;
    logic            w_pop;
    logic            w_push;
    logic            w_close;

    always_ff @(posedge masterclk) begin
        if (rst) begin
            for (int i = 0; i < int'(NB); i++) begin
                r_bank_st[i] <= B_FREE;
                r_len[i]     <= '0;
                r_fifo[i]    <= '0;
            end
            r_fifo_cnt <= '0;
            r_wr_state <= W_IDLE;
            r_wr_bank  <= '0;
            r_wr_ptr   <= '0;
            r_rd_state <= R_IDLE;
            r_rd_bank  <= '0;
            r_rd_ptr   <= '0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_bank_st  <= w_bank_st;
            r_len      <= w_len;
            r_fifo     <= w_fifo;
            r_fifo_cnt <= w_fifo_cnt;
            r_wr_state <= w_wr_state;
            r_wr_bank  <= w_wr_bank;
            r_wr_ptr   <= w_wr_ptr;
            r_rd_state <= w_rd_state;
            r_rd_bank  <= w_rd_bank;
            r_rd_ptr   <= w_rd_ptr;
            r_overrun  <= w_overrun;
            r_underrun <= w_underrun;
        end
    end

    always_comb begin
        w_bank_st    = r_bank_st;
        w_len        = r_len;
        w_fifo       = r_fifo;
        w_fifo_cnt   = r_fifo_cnt;
        w_wr_state   = r_wr_state;
        w_wr_bank    = r_wr_bank;
        w_wr_ptr     = r_wr_ptr;
        w_rd_state   = r_rd_state;
        w_rd_bank    = r_rd_bank;
        w_rd_ptr     = r_rd_ptr;
        w_overrun    = r_overrun;
        w_underrun   = r_underrun;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_pop        = 1'b0;
        w_push       = 1'b0;

        wr_en    = (r_wr_state == W_FILL) && in_pix_en && (r_wr_ptr < LINE_MAX);
        rd_valid = (r_rd_state != R_IDLE) && (r_rd_ptr < r_len[r_rd_bank]);
        w_close  = (r_wr_state == W_FILL) && (in_line_end || in_line_start);

        // Claim search uses registered state only, so banks freed or closed this cycle are excluded
        for (int i = 0; i < int'(NB); i++) begin
            if (!w_free_found && r_bank_st[i] == B_FREE) begin
                w_free_found = 1'b1;
                w_free_idx   = BW'(i);
            end
        end

        if (out_line_start) begin
            unique case (r_rd_state)
                R_PASS0: begin
                    w_rd_ptr   = '0;
                    w_rd_state = R_PASS1;
                end
                R_IDLE, R_PASS1: begin
                    if (r_rd_state == R_PASS1) w_bank_st[r_rd_bank] = B_FREE;
                    if (r_fifo_cnt != '0) begin
                        w_pop                = 1'b1;
                        w_rd_bank            = r_fifo[0];
                        w_bank_st[r_fifo[0]] = B_READING;
                        w_rd_ptr             = '0;
                        w_rd_state           = R_PASS0;
                    end else begin
                        w_underrun = 1'b1;
                        w_rd_state = R_IDLE;
                    end
                end
                default: w_rd_state = R_IDLE;
            endcase
        end else if (out_pix_en && rd_valid) begin
            w_rd_ptr = r_rd_ptr + LW'(1);
        end

        if (wr_en) w_wr_ptr = r_wr_ptr + LW'(1);

        if (w_close) begin
            w_len[r_wr_bank]     = r_wr_ptr + LW'(wr_en);
            w_bank_st[r_wr_bank] = B_READY;
            w_push               = 1'b1;
            w_wr_state           = W_IDLE;
        end

        if (in_line_start) begin
            if (w_free_found) begin
                w_wr_bank             = w_free_idx;
                w_bank_st[w_free_idx] = B_WRITING;
                w_wr_ptr              = '0;
                w_wr_state            = W_FILL;
            end else begin
                w_overrun = 1'b1;
            end
        end

        // Pop acts on the registered queue before the push is appended
        if (w_pop) begin
            for (int i = 0; i < int'(NB) - 1; i++) w_fifo[i] = r_fifo[i+1];
        end
        w_fifo_cnt = r_fifo_cnt - 2'(w_pop);
        if (w_push) begin
            w_fifo[w_fifo_cnt] = r_wr_bank;
            w_fifo_cnt         = w_fifo_cnt + 2'd1;
        end
    end

    assign wr_addr  = {r_wr_bank, r_wr_ptr[ADDR_W-1:0]};
    assign rd_addr  = {r_rd_bank, r_rd_ptr[ADDR_W-1:0]};
    assign overrun  = r_overrun;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_fd_linebuf_sched.sv
// Bench for fd_linebuf_sched: directed scenarios plus a randomized run against a
// queue-based model of bank ownership and line replay.
module tb_fd_linebuf_sched;
    localparam int unsigned ADDR_W = 8;
    localparam int LINE = 256;
    localparam int M_FREE = 0, M_WRITING = 1, M_READY = 2, M_READING = 3;

    logic masterclk = 1'b0;
    logic rst = 1'b1;
    logic in_line_start = 1'b0, in_pix_en = 1'b0, in_line_end = 1'b0;
    logic out_line_start = 1'b0, out_pix_en = 1'b0;
    logic wr_en, rd_valid, overrun, underrun;
    logic [ADDR_W+1:0] wr_addr, rd_addr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_st [3];
    int m_len [3];
    int m_rq [$];
    bit m_wact;
    int m_wbank, m_wcnt;
    int m_rph, m_rbank, m_rpos;
    bit m_over, m_under;
    bit e_wr_en, e_rd_valid;
    logic [ADDR_W+1:0] e_wr_addr, e_rd_addr;

    fd_linebuf_sched #(.ADDR_W(ADDR_W)) dut (
        .masterclk      (masterclk),
        .rst            (rst),
        .in_line_start  (in_line_start),
        .in_pix_en      (in_pix_en),
        .in_line_end    (in_line_end),
        .out_line_start (out_line_start),
        .out_pix_en     (out_pix_en),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .rd_addr        (rd_addr),
        .rd_valid       (rd_valid),
        .overrun        (overrun),
        .underrun       (underrun)
    );

    always #5 masterclk = ~masterclk;

    function automatic void predict();
        e_wr_en    = m_wact && in_pix_en && (m_wcnt < LINE);
        e_wr_addr  = 10'(m_wbank * LINE + (m_wcnt % LINE));
        e_rd_valid = (m_rph != 0) && (m_rpos < m_len[m_rbank]);
        e_rd_addr  = 10'(m_rbank * LINE + (m_rpos % LINE));
    endfunction

    task automatic model_update();
        int old_st [3];
        int fb;
        bit wen, rv;
        predict();
        wen = e_wr_en;
        rv  = e_rd_valid;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin m_st[i] = M_FREE; m_len[i] = 0; end
            m_rq.delete();
            m_wact = 0; m_wbank = 0; m_wcnt = 0;
            m_rph = 0; m_rbank = 0; m_rpos = 0;
            m_over = 0; m_under = 0;
            return;
        end
        old_st = m_st;
        if (out_line_start) begin
            if (m_rph == 1) begin
                m_rph = 2; m_rpos = 0;
            end else begin
                if (m_rph == 2) m_st[m_rbank] = M_FREE;
                if (m_rq.size() > 0) begin
                    m_rbank = m_rq.pop_front();
                    m_st[m_rbank] = M_READING;
                    m_rph = 1; m_rpos = 0;
                end else begin
                    m_under = 1; m_rph = 0;
                end
            end
        end else if (out_pix_en && rv) begin
            m_rpos++;
        end
        if (m_wact) begin
            if (wen) m_wcnt++;
            if (in_line_end || in_line_start) begin
                m_len[m_wbank] = m_wcnt;
                m_st[m_wbank] = M_READY;
                m_rq.push_back(m_wbank);
                m_wact = 0;
            end
        end
        if (in_line_start) begin
            fb = -1;
            for (int i = 0; i < 3; i++) if (fb < 0 && old_st[i] == M_FREE) fb = i;
            if (fb >= 0) begin
                m_wbank = fb; m_st[fb] = M_WRITING; m_wcnt = 0; m_wact = 1;
            end else begin
                m_over = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge masterclk);
        model_update();
        @(negedge masterclk);
        rst = 0; in_line_start = 0; in_pix_en = 0; in_line_end = 0;
        out_line_start = 0; out_pix_en = 0;
    endtask

    task automatic do_reset();
        rst = 1; tick();
        rst = 1; tick();
    endtask

    task automatic feed_line(input int n);
        in_line_start = 1; tick();
        for (int i = 0; i < n; i++) begin in_pix_en = 1; tick(); end
        in_line_end = 1; tick();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (wr_en !== 1'b0 || rd_valid !== 1'b0 || overrun !== 1'b0 || underrun !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: wr_en=%b rd_valid=%b overrun=%b underrun=%b, want all 0",
                     wr_en, rd_valid, overrun, underrun);
        end
        n_checks++;
        if (wr_addr !== 10'h000 || rd_addr !== 10'h000) begin
            n_errors++;
            $display("FAIL reset_addr: wr_addr=%h rd_addr=%h, want 000/000", wr_addr, rd_addr);
        end
    endtask

    task automatic test_full_line();
        logic [9:0] exp_a;
        do_reset();
        in_line_start = 1; tick();
        for (int i = 0; i < LINE; i++) begin
            in_pix_en = 1; #1;
            exp_a = 10'(i);
            n_checks++;
            if (wr_en !== 1'b1 || wr_addr !== exp_a) begin
                n_errors++;
                $display("FAIL full_wr[%0d]: wr_en=%b wr_addr=%h, want 1/%h", i, wr_en, wr_addr, exp_a);
            end
            tick();
        end
        in_pix_en = 1; #1;
        n_checks++;
        if (wr_en !== 1'b0) begin
            n_errors++;
            $display("FAIL full_wr_cap: wr_en=%b, want 0 past 256 pixels", wr_en);
        end
        tick();
        in_line_end = 1; tick();
        for (int p = 0; p < 2; p++) begin
            out_line_start = 1; tick();
            for (int i = 0; i < LINE; i++) begin
                out_pix_en = 1; #1;
                exp_a = 10'(i);
                n_checks++;
                if (rd_valid !== 1'b1 || rd_addr !== exp_a) begin
                    n_errors++;
                    $display("FAIL full_rd[p%0d,%0d]: rd_valid=%b rd_addr=%h, want 1/%h",
                             p, i, rd_valid, rd_addr, exp_a);
                end
                tick();
            end
            #1;
            n_checks++;
            if (rd_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL full_rd_end[p%0d]: rd_valid=%b, want 0", p, rd_valid);
            end
        end
        // Third output line releases bank 0; a new input line must land there
        out_line_start = 1; tick();
        in_line_start = 1; tick();
        in_pix_en = 1; #1;
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 10'h000) begin
            n_errors++;
            $display("FAIL full_reclaim: wr_en=%b wr_addr=%h, want 1/000", wr_en, wr_addr);
        end
        tick();
    endtask

    task automatic test_underrun_idle();
        do_reset();
        out_line_start = 1; tick();
        #1;
        n_checks++;
        if (underrun !== 1'b1) begin
            n_errors++;
            $display("FAIL underrun_idle: underrun=%b, want 1", underrun);
        end
        for (int i = 0; i < LINE; i++) begin
            out_pix_en = 1; #1;
            n_checks++;
            if (rd_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL underrun_blank[%0d]: rd_valid=%b, want 0", i, rd_valid);
            end
            tick();
        end
    endtask

    task automatic test_overrun();
        logic [9:0] exp_a;
        do_reset();
        for (int l = 0; l < 3; l++) begin
            in_line_start = 1; tick();
            for (int i = 0; i < LINE; i++) begin
                in_pix_en = 1;
                if (i == 0) begin
                    #1;
                    exp_a = 10'(l * LINE);
                    n_checks++;
                    if (wr_en !== 1'b1 || wr_addr !== exp_a) begin
                        n_errors++;
                        $display("FAIL ovr_bank[%0d]: wr_en=%b wr_addr=%h, want 1/%h", l, wr_en, wr_addr, exp_a);
                    end
                end
                tick();
            end
            in_line_end = 1; tick();
        end
        in_line_start = 1; tick();
        #1;
        n_checks++;
        if (overrun !== 1'b1) begin
            n_errors++;
            $display("FAIL overrun_flag: overrun=%b, want 1", overrun);
        end
        for (int i = 0; i < 10; i++) begin
            in_pix_en = 1; #1;
            n_checks++;
            if (wr_en !== 1'b0) begin
                n_errors++;
                $display("FAIL ovr_dropped[%0d]: wr_en=%b, want 0", i, wr_en);
            end
            tick();
        end
        in_line_end = 1; tick();
        for (int b = 0; b < 3; b++) begin
            out_line_start = 1; tick();
            out_pix_en = 1; #1;
            exp_a = 10'(b * LINE);
            n_checks++;
            if (rd_valid !== 1'b1 || rd_addr !== exp_a) begin
                n_errors++;
                $display("FAIL ovr_order[%0d]: rd_valid=%b rd_addr=%h, want 1/%h", b, rd_valid, rd_addr, exp_a);
            end
            tick();
            out_line_start = 1; tick();
        end
    endtask

    task automatic test_short_line();
        bit exp_v;
        do_reset();
        feed_line(100);
        for (int p = 0; p < 2; p++) begin
            out_line_start = 1; tick();
            for (int i = 0; i < LINE; i++) begin
                out_pix_en = 1; #1;
                exp_v = (i < 100);
                n_checks++;
                if (rd_valid !== exp_v || (exp_v && rd_addr !== 10'(i))) begin
                    n_errors++;
                    $display("FAIL short_rd[p%0d,%0d]: rd_valid=%b rd_addr=%h, want %b/%h",
                             p, i, rd_valid, rd_addr, exp_v, 10'(i));
                end
                tick();
            end
        end
    endtask

    task automatic test_end_start_same();
        do_reset();
        in_line_start = 1; tick();
        for (int i = 0; i < 5; i++) begin in_pix_en = 1; tick(); end
        in_line_end = 1; out_line_start = 1; tick();
        #1;
        n_checks++;
        if (underrun !== 1'b1 || rd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL same_cycle: underrun=%b rd_valid=%b, want 1/0", underrun, rd_valid);
        end
        out_line_start = 1; tick();
        for (int i = 0; i < 6; i++) begin
            out_pix_en = 1; #1;
            n_checks++;
            if (rd_valid !== (i < 5) || (i < 5 && rd_addr !== 10'(i))) begin
                n_errors++;
                $display("FAIL same_cycle_rd[%0d]: rd_valid=%b rd_addr=%h, want %b/%h",
                         i, rd_valid, rd_addr, (i < 5), 10'(i));
            end
            tick();
        end
    endtask

    task automatic test_reset_midline();
        do_reset();
        feed_line(10);
        in_line_start = 1; tick();
        for (int i = 0; i < 50; i++) begin
            in_pix_en = 1;
            if (i == 0) begin
                #1;
                n_checks++;
                if (wr_addr !== 10'h100) begin
                    n_errors++;
                    $display("FAIL midline_bank1: wr_addr=%h, want 100", wr_addr);
                end
            end
            tick();
        end
        rst = 1; tick();
        in_pix_en = 1; #1;
        n_checks++;
        if (wr_en !== 1'b0 || rd_valid !== 1'b0 || wr_addr !== 10'h000 || rd_addr !== 10'h000 ||
            overrun !== 1'b0 || underrun !== 1'b0) begin
            n_errors++;
            $display("FAIL midline_reset: wr_en=%b rd_valid=%b wr_addr=%h rd_addr=%h ovr=%b und=%b, want 0/0/000/000/0/0",
                     wr_en, rd_valid, wr_addr, rd_addr, overrun, underrun);
        end
        tick();
        in_line_start = 1; tick();
        for (int i = 0; i < 3; i++) begin
            in_pix_en = 1; #1;
            n_checks++;
            if (wr_en !== 1'b1 || wr_addr !== 10'(i)) begin
                n_errors++;
                $display("FAIL midline_restart[%0d]: wr_en=%b wr_addr=%h, want 1/%h", i, wr_en, wr_addr, 10'(i));
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst            = ($urandom_range(1999) == 0);
            in_line_start  = ($urandom_range(79) == 0);
            in_line_end    = ($urandom_range(59) == 0);
            in_pix_en      = ($urandom_range(3) != 0);
            out_line_start = ($urandom_range(99) == 0);
            out_pix_en     = ($urandom_range(3) != 0);
            #1;
            predict();
            n_checks++;
            if (wr_en !== e_wr_en || (e_wr_en && wr_addr !== e_wr_addr)) begin
                n_errors++;
                $display("FAIL rand_wr[%0d]: wr_en=%b wr_addr=%h, want %b/%h", c, wr_en, wr_addr, e_wr_en, e_wr_addr);
            end
            n_checks++;
            if (rd_valid !== e_rd_valid || (e_rd_valid && rd_addr !== e_rd_addr)) begin
                n_errors++;
                $display("FAIL rand_rd[%0d]: rd_valid=%b rd_addr=%h, want %b/%h", c, rd_valid, rd_addr, e_rd_valid, e_rd_addr);
            end
            n_checks++;
            if (overrun !== m_over || underrun !== m_under) begin
                n_errors++;
                $display("FAIL rand_flags[%0d]: overrun=%b underrun=%b, want %b/%b", c, overrun, underrun, m_over, m_under);
            end
            tick();
        end
    endtask

    initial begin
        @(negedge masterclk);
        test_reset();
        test_full_line();
        test_underrun_idle();
        test_overrun();
        test_short_line();
        test_end_start_same();
        test_reset_midline();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
